rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
- Upstream sequencer for the LIFO stack block: accepts a stream of RPN tokens (numbers and operators) over a valid/ready handshake.
- Translates each token into a timed sequence of stack operations (PUSH/POP) plus ALU results, observing the stack's top two entries and its sp/full/empty status.
- Sits between the token source (instruction decoder or testbench) and the stack; the stack holds its state in any cycle where stk_en is low.

Parameters:
- DATA_WIDTH, 8, width of numbers, stack entries and ALU result
- STACK_DEPTH, 16, depth of the attached stack; usable capacity is STACK_DEPTH-1 because stack_full asserts at sp==STACK_DEPTH-1
- ADDR_WIDTH, $clog2(STACK_DEPTH), width of stk_sp

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tok_valid  in  1  token present
- tok_ready  out  1  controller can accept a token this cycle
- tok_is_op  in  1  0 = number, 1 = operator
- tok_data  in  DATA_WIDTH  number value, or opcode in bits [2:0] when tok_is_op=1
- stk_top0  in  DATA_WIDTH  stack q[0] (top)
- stk_top1  in  DATA_WIDTH  stack q[1]
- stk_sp  in  ADDR_WIDTH  stack entry count
- stk_full  in  1  stack full
- stk_empty  in  1  stack empty
- stk_en  out  1  stack performs stk_op at the next clock edge
- stk_op  out  2  01 = PUSH, 10 = POP (00 and 11 never driven)
- stk_d  out  DATA_WIDTH  data for PUSH
- busy  out  1  sequence in progress (inverse of tok_ready)
- err_underflow  out  1  sticky: operator lacked operands
- err_overflow  out  1  sticky: push attempted while stack full
- clr_err  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async, any state): state=IDLE, tok_ready=1, stk_en=0, stk_op=00, stk_d=0, busy=0, err_underflow=0, err_overflow=0, operand latches A=B=0. A reset mid-sequence abandons the remaining ops; the stack is reset by the same rst_n.
- All outputs are registered. tok_ready=1 only in IDLE. A token is accepted on an edge where tok_valid&tok_ready; on that edge B<=stk_top0, A<=stk_top1, and stk_sp, stk_full are sampled.
- Opcodes: 0 ADD (A+B), 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 DUP, 6 SWAP, 7 DROP. Arithmetic is modulo 2^DATA_WIDTH; no carry/borrow flag.
- States: IDLE, OP1, OP2, OP3, OP4. Each non-IDLE state drives exactly one stk_en=1 cycle; the last state returns to IDLE. One stack op is issued per cycle.
- Number: OP1 PUSH d=tok_data. 1 op; tok_ready is low for 1 cycle.
- ADD..XOR: OP1 POP, OP2 POP, OP3 PUSH result. 3 ops.
- DUP: OP1 PUSH B.
- SWAP: OP1 POP, OP2 POP, OP3 PUSH B, OP4 PUSH A. Net order after the swap: top=A, next=B.
- DROP: OP1 POP.
- Operand requirements at acceptance: binary ops and SWAP need stk_sp>=2; DUP and DROP need stk_sp>=1. If the requirement is not met: the token is consumed, no stk_en is issued, err_underflow<=1, and the state stays IDLE.
- Number or DUP accepted while stk_full=1: the token is consumed, no stk_en is issued, and err_overflow<=1. Binary ops and SWAP cannot overflow, because they pop before pushing.
- Both underflow and overflow conditions present (DUP with sp==0 and full): not reachable. Underflow check takes priority.
- clr_err=1 clears both flags on the next edge. If a new error is detected on the same edge, set wins.
- stk_d holds its last value when stk_en=0. stk_op=00 when stk_en=0.

Test Plan:
- Reset, then push numbers 5 and 3, then ADD -> stack ops PUSH 5, PUSH 3, POP, POP, PUSH 8; final stk_top0=8, sp=1; tok_ready low exactly 3 cycles for ADD.
- Push 3, push 5, SUB -> result 0xFE (3-5 mod 256); push 0xF0, push 0x20, ADD -> 0x10 (wrap).
- Push 1, push 2, SWAP -> ops POP, POP, PUSH 2, PUSH 1; top0=1, top1=2. Then DUP -> top0=1, sp=3. Then DROP -> sp=2.
- Empty stack, ADD -> no stk_en, err_underflow=1, tok_ready returns high next cycle. Then clr_err=1 -> flag 0. Then clr_err together with DROP on empty -> flag stays 1.
- Push 15 numbers (sp=15, full), push 16th -> no stk_en, err_overflow=1, sp stays 15. DUP -> err_overflow stays 1. ADD succeeds with sp=14.
- Assert rst_n=0 during OP2 of XOR -> all outputs at reset values immediately, stk_en=0. After release, tok_ready=1 and the next number token is handled normally.

Source files
------------

// File: rtl/rpn_stack_ctrl.sv
// Turns RPN tokens into timed PUSH/POP sequences for an attached LIFO stack, one stack op per cycle.
// Numbers, DUP and DROP take 1 op, ADD..XOR take 3 ops and SWAP takes 4; tok_ready is low while a sequence runs.
module rpn_stack_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_WIDTH  = $clog2(STACK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic                  tok_is_op,
    input  logic [DATA_WIDTH-1:0] tok_data,
    input  logic [DATA_WIDTH-1:0] stk_top0,
    input  logic [DATA_WIDTH-1:0] stk_top1,
    input  logic [ADDR_WIDTH-1:0] stk_sp,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic                  stk_en,
    output logic [1:0]            stk_op,
    output logic [DATA_WIDTH-1:0] stk_d,
    output logic                  busy,
    output logic                  err_underflow,
    output logic                  err_overflow,
    input  logic                  clr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_OP2,
        S_OP3,
        S_OP4
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;

    localparam logic [2:0] OPC_ADD  = 3'd0;
    localparam logic [2:0] OPC_SUB  = 3'd1;
    localparam logic [2:0] OPC_AND  = 3'd2;
    localparam logic [2:0] OPC_OR   = 3'd3;
    localparam logic [2:0] OPC_XOR  = 3'd4;
    localparam logic [2:0] OPC_DUP  = 3'd5;
    localparam logic [2:0] OPC_SWAP = 3'd6;
    localparam logic [2:0] OPC_DROP = 3'd7;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] w_a_nxt;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic [2:0]            r_opc;
    logic [2:0]            w_opc_nxt;
    logic                  r_is_op;
    logic                  w_is_op_nxt;
    logic                  r_tok_ready;
    logic                  r_busy;
    logic                  r_stk_en;
    logic                  w_stk_en_nxt;
    logic [1:0]            r_stk_op;
    logic [1:0]            w_stk_op_nxt;
    logic [DATA_WIDTH-1:0] r_stk_d;
    logic [DATA_WIDTH-1:0] w_stk_d_nxt;
    logic                  r_err_uf;
    logic                  w_err_uf_nxt;
    logic                  r_err_of;
    logic                  w_err_of_nxt;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_accept;
    logic                  w_need_two;
    logic                  w_need_one;
    logic                  w_pushes;
    logic                  w_single;

    assign w_accept = tok_valid & r_tok_ready;

    // Operand and capacity classes of the token being offered.
    always_comb begin
        w_need_two = 1'b0;
        w_need_one = 1'b0;
        w_pushes   = 1'b0;
        if (!tok_is_op) begin
            w_pushes = 1'b1;
        end else begin
            case (tok_data[2:0])
                OPC_DUP: begin
                    w_need_one = 1'b1;
                    w_pushes   = 1'b1;
                end
                OPC_DROP: w_need_one = 1'b1;
                default:  w_need_two = 1'b1;
            endcase
        end
    end

    // Latched operand A is the entry below the top, B is the top.
    always_comb begin
        w_alu = '0;
        case (r_opc)
            OPC_ADD: w_alu = r_a + r_b;
            OPC_SUB: w_alu = r_a - r_b;
            OPC_AND: w_alu = r_a & r_b;
            OPC_OR:  w_alu = r_a | r_b;
            OPC_XOR: w_alu = r_a ^ r_b;
            default: w_alu = '0;
        endcase
    end

    assign w_single = !r_is_op || (r_opc == OPC_DUP) || (r_opc == OPC_DROP);

    // Outputs are computed one cycle early and registered with the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_opc_nxt    = r_opc;
        w_is_op_nxt  = r_is_op;
        w_stk_en_nxt = 1'b0;
        w_stk_op_nxt = OP_NONE;
        w_stk_d_nxt  = r_stk_d;
        w_err_uf_nxt = r_err_uf & ~clr_err;
        w_err_of_nxt = r_err_of & ~clr_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_a_nxt     = stk_top1;
                    w_b_nxt     = stk_top0;
                    w_opc_nxt   = tok_data[2:0];
                    w_is_op_nxt = tok_is_op;
                    if (w_need_two && (stk_sp < ADDR_WIDTH'(2))) begin
                        w_err_uf_nxt = 1'b1;
                    end else if (w_need_one && stk_empty) begin
                        w_err_uf_nxt = 1'b1;
                    end else if (w_pushes && stk_full) begin
                        w_err_of_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_OP1;
                        w_stk_en_nxt = 1'b1;
                        if (w_pushes) begin
                            w_stk_op_nxt = OP_PUSH;
                            w_stk_d_nxt  = tok_is_op ? stk_top0 : tok_data;
                        end else begin
                            w_stk_op_nxt = OP_POP;
                        end
                    end
                end
            end
            S_OP1: begin
                if (w_single) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt  = S_OP2;
                    w_stk_en_nxt = 1'b1;
                    w_stk_op_nxt = OP_POP;
                end
            end
            S_OP2: begin
                w_state_nxt  = S_OP3;
                w_stk_en_nxt = 1'b1;
                w_stk_op_nxt = OP_PUSH;
                w_stk_d_nxt  = (r_opc == OPC_SWAP) ? r_b : w_alu;
            end
            S_OP3: begin
                if (r_opc == OPC_SWAP) begin
                    w_state_nxt  = S_OP4;
                    w_stk_en_nxt = 1'b1;
                    w_stk_op_nxt = OP_PUSH;
                    w_stk_d_nxt  = r_a;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OP4: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_opc       <= '0;
            r_is_op     <= 1'b0;
            r_tok_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_stk_en    <= 1'b0;
            r_stk_op    <= OP_NONE;
            r_stk_d     <= '0;
            r_err_uf    <= 1'b0;
            r_err_of    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_opc       <= w_opc_nxt;
            r_is_op     <= w_is_op_nxt;
            r_tok_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_stk_en    <= w_stk_en_nxt;
            r_stk_op    <= w_stk_op_nxt;
            r_stk_d     <= w_stk_d_nxt;
            r_err_uf    <= w_err_uf_nxt;
            r_err_of    <= w_err_of_nxt;
        end
    end

    assign tok_ready     = r_tok_ready;
    assign busy          = r_busy;
    assign stk_en        = r_stk_en;
    assign stk_op        = r_stk_op;
    assign stk_d         = r_stk_d;
    assign err_underflow = r_err_uf;
    assign err_overflow  = r_err_of;

endmodule
